// File: rtl/aw_channel_arbiter.sv
// Two-master AXI write-address arbiter. It grants one master, passes its AW handshake to the shared
// decoder, owns the shared W channel until wlast, and counts bursts that are still waiting for a B response.
module aw_channel_arbiter #(
  parameter int Max_Outstanding = 4,
  parameter int Cnt_Width       = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 S00_AXI_awvalid,
  input  logic                 S01_AXI_awvalid,
  output logic                 S00_AXI_awready,
  output logic                 S01_AXI_awready,
  output logic                 AW_awvalid,
  input  logic                 AW_awready,
  output logic                 AW_Sel,
  input  logic                 W_wvalid,
  input  logic                 W_wready,
  input  logic                 W_wlast,
  output logic                 W_Enable,
  output logic                 W_Sel,
  input  logic                 B_bvalid,
  input  logic                 B_bready,
  output logic                 Grant_Valid,
  output logic [Cnt_Width-1:0] Outstanding_Cnt
);

  localparam logic [Cnt_Width-1:0] MAX_CNT = Cnt_Width'(Max_Outstanding);
  localparam logic [Cnt_Width-1:0] ONE     = Cnt_Width'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_aw_sel;
  logic                 r_last_grant;
  logic [Cnt_Width-1:0] r_cnt;

  logic w_in_addr;
  logic w_in_data;
  logic w_room;
  logic w_any_req;
  logic w_pick;
  logic w_gnt_awvalid;
  logic w_aw_hs;
  logic w_w_last_hs;
  logic w_b_hs;

  assign w_in_addr = (r_state == ADDR);
  assign w_in_data = (r_state == DATA);
  assign w_room    = (r_cnt < MAX_CNT);
  assign w_any_req = S00_AXI_awvalid | S01_AXI_awvalid;

  // On contention, grant the master that was not granted last. A lone requester always wins.
  assign w_pick = (S00_AXI_awvalid & S01_AXI_awvalid) ? ~r_last_grant : S01_AXI_awvalid;

  assign w_gnt_awvalid = r_aw_sel ? S01_AXI_awvalid : S00_AXI_awvalid;

  assign AW_awvalid      = w_in_addr & w_gnt_awvalid;
  assign S00_AXI_awready = w_in_addr & ~r_aw_sel & AW_awready;
  assign S01_AXI_awready = w_in_addr &  r_aw_sel & AW_awready;
  assign AW_Sel          = r_aw_sel;

  assign W_Enable    = w_in_data;
  assign W_Sel       = w_in_data & r_aw_sel;
  assign Grant_Valid = w_in_addr | w_in_data;

  assign w_aw_hs     = AW_awvalid & AW_awready;
  assign w_w_last_hs = w_in_data & W_wvalid & W_wready & W_wlast;
  // A B response that arrives with nothing outstanding is ignored, so the counter cannot underflow.
  assign w_b_hs      = B_bvalid & B_bready & (r_cnt != '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= IDLE;
      r_aw_sel     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req && w_room) begin
            r_aw_sel <= w_pick;
            r_state  <= ADDR;
          end
        end
        ADDR: begin
          if (w_aw_hs) r_state <= DATA;
        end
        DATA: begin
          if (w_w_last_hs) begin
            r_last_grant <= r_aw_sel;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // An AW handshake and a B handshake in the same cycle cancel out.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign Outstanding_Cnt = r_cnt;

endmodule

// File: tb/tb_aw_channel_arbiter.sv
// Directed bench for aw_channel_arbiter. Each step drives inputs and then checks outputs 1 ns after
// the rising edge against hand-derived values.
module tb_aw_channel_arbiter;

  logic       ACLK;
  logic       ARESETN;
  logic       S00_AXI_awvalid, S01_AXI_awvalid;
  logic       S00_AXI_awready, S01_AXI_awready;
  logic       AW_awvalid, AW_awready, AW_Sel;
  logic       W_wvalid, W_wready, W_wlast;
  logic       W_Enable, W_Sel;
  logic       B_bvalid, B_bready;
  logic       Grant_Valid;
  logic [3:0] Outstanding_Cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  aw_channel_arbiter #(.Max_Outstanding(4), .Cnt_Width(4)) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .S00_AXI_awvalid (S00_AXI_awvalid),
    .S01_AXI_awvalid (S01_AXI_awvalid),
    .S00_AXI_awready (S00_AXI_awready),
    .S01_AXI_awready (S01_AXI_awready),
    .AW_awvalid      (AW_awvalid),
    .AW_awready      (AW_awready),
    .AW_Sel          (AW_Sel),
    .W_wvalid        (W_wvalid),
    .W_wready        (W_wready),
    .W_wlast         (W_wlast),
    .W_Enable        (W_Enable),
    .W_Sel           (W_Sel),
    .B_bvalid        (B_bvalid),
    .B_bready        (B_bready),
    .Grant_Valid     (Grant_Valid),
    .Outstanding_Cnt (Outstanding_Cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Starts in IDLE with the requests already driven. It runs a grant, an AW handshake and a single-beat
  // W burst. If b_in_w is set, a B response is returned during the W beat.
  task automatic burst(input logic exp_sel, input logic b_in_w);
    step();
    chk("gnt_gv", Grant_Valid, 1);
    chk("gnt_sel", AW_Sel, exp_sel);
    chk("gnt_awvalid", AW_awvalid, 1);
    chk("gnt_wen", W_Enable, 0);
    chk("gnt_rdy_own", exp_sel ? S01_AXI_awready : S00_AXI_awready, 1);
    chk("gnt_rdy_oth", exp_sel ? S00_AXI_awready : S01_AXI_awready, 0);
    step();
    exp_cnt++;
    chk("aw_cnt", Outstanding_Cnt, exp_cnt);
    chk("data_wen", W_Enable, 1);
    chk("data_wsel", W_Sel, exp_sel);
    W_wvalid = 1; W_wready = 1; W_wlast = 1;
    B_bvalid = b_in_w; B_bready = b_in_w;
    step();
    if (b_in_w) exp_cnt--;
    W_wvalid = 0; W_wready = 0; W_wlast = 0; B_bvalid = 0; B_bready = 0;
    chk("end_gv", Grant_Valid, 0);
    chk("end_awvalid", AW_awvalid, 0);
    chk("end_cnt", Outstanding_Cnt, exp_cnt);
  endtask

  initial begin
    ARESETN = 0;
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 0; AW_awready = 1;
    W_wvalid = 0; W_wready = 0; W_wlast = 0; B_bvalid = 0; B_bready = 0;
    exp_cnt = 0;

    // Reset state
    step(); step();
    chk("rst_gv", Grant_Valid, 0);
    chk("rst_wen", W_Enable, 0);
    chk("rst_wsel", W_Sel, 0);
    chk("rst_awvalid", AW_awvalid, 0);
    chk("rst_rdy0", S00_AXI_awready, 0);
    chk("rst_rdy1", S01_AXI_awready, 0);
    chk("rst_awsel", AW_Sel, 0);
    chk("rst_cnt", Outstanding_Cnt, 0);

    // Master 0 alone, with a 4-beat W burst
    ARESETN = 1; S00_AXI_awvalid = 1;
    #1;
    chk("idle_awvalid", AW_awvalid, 0);
    chk("idle_rdy0", S00_AXI_awready, 0);
    step();
    chk("m0_gv", Grant_Valid, 1);
    chk("m0_sel", AW_Sel, 0);
    chk("m0_awvalid", AW_awvalid, 1);
    chk("m0_rdy0", S00_AXI_awready, 1);
    chk("m0_cnt0", Outstanding_Cnt, 0);
    step();
    S00_AXI_awvalid = 0;
    #1;
    chk("m0_cnt1", Outstanding_Cnt, 1);
    chk("m0_wen", W_Enable, 1);
    chk("m0_wsel", W_Sel, 0);
    chk("m0_awvalid_data", AW_awvalid, 0);
    for (int b = 1; b <= 4; b++) begin
      W_wvalid = 1; W_wready = 1; W_wlast = (b == 4);
      #1;
      chk("m0_beat_wen", W_Enable, 1);
      step();
    end
    W_wvalid = 0; W_wready = 0; W_wlast = 0;
    chk("m0_after_gv", Grant_Valid, 0);
    chk("m0_after_wen", W_Enable, 0);
    chk("m0_after_cnt", Outstanding_Cnt, 1);
    B_bvalid = 1; B_bready = 1;
    step();
    B_bvalid = 0; B_bready = 0;
    chk("m0_b_cnt", Outstanding_Cnt, 0);

    // An async reset pulse restores last_grant to 1, so master 0 wins first contention
    ARESETN = 0;
    #1;
    chk("pulse_gv", Grant_Valid, 0);
    step();
    ARESETN = 1;
    exp_cnt = 0;
    S00_AXI_awvalid = 1; S01_AXI_awvalid = 1;
    burst(1'b0, 1'b1);
    burst(1'b1, 1'b1);
    burst(1'b0, 1'b1);
    burst(1'b1, 1'b1);
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 0;

    // Fill to Max_Outstanding with no B responses
    S00_AXI_awvalid = 1;
    for (int i = 0; i < 4; i++) burst(1'b0, 1'b0);
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_gv", Grant_Valid, 0);
      chk("full_rdy1", S01_AXI_awready, 0);
      chk("full_cnt", Outstanding_Cnt, 4);
    end
    B_bvalid = 1; B_bready = 1;
    step();
    B_bvalid = 0; B_bready = 0;
    chk("b_cnt3", Outstanding_Cnt, 3);
    chk("b_gv", Grant_Valid, 0);
    step();
    chk("m1_gv", Grant_Valid, 1);
    chk("m1_sel", AW_Sel, 1);

    // The granted master drops awvalid while B drains one burst; the grant must be held
    S01_AXI_awvalid = 0; B_bvalid = 1; B_bready = 1;
    #1;
    chk("drop_awvalid", AW_awvalid, 0);
    step();
    chk("drop_gv", Grant_Valid, 1);
    chk("drop_wen", W_Enable, 0);
    chk("drop_cnt", Outstanding_Cnt, 2);

    // AW and B handshakes in the same cycle
    S01_AXI_awvalid = 1;
    #1;
    chk("both_awvalid", AW_awvalid, 1);
    step();
    B_bvalid = 0; B_bready = 0; S01_AXI_awvalid = 0;
    chk("both_cnt", Outstanding_Cnt, 2);
    chk("both_wen", W_Enable, 1);
    chk("both_wsel", W_Sel, 1);
    W_wvalid = 1; W_wready = 1; W_wlast = 1;
    step();
    W_wvalid = 0; W_wready = 0; W_wlast = 0;
    chk("m1_end_gv", Grant_Valid, 0);

    // Reach DATA with a count of 3, then reset
    exp_cnt = 2;
    S00_AXI_awvalid = 1;
    step();
    chk("r_gnt_sel", AW_Sel, 0);
    step();
    S00_AXI_awvalid = 0;
    chk("r_data_wen", W_Enable, 1);
    chk("r_data_cnt", Outstanding_Cnt, 3);
    ARESETN = 0;
    #1;
    chk("mid_rst_gv", Grant_Valid, 0);
    chk("mid_rst_wen", W_Enable, 0);
    chk("mid_rst_cnt", Outstanding_Cnt, 0);
    chk("mid_rst_awsel", AW_Sel, 0);
    step();
    ARESETN = 1;

    // A B handshake at zero count must not underflow
    B_bvalid = 1; B_bready = 1;
    step();
    B_bvalid = 0; B_bready = 0;
    chk("b_zero_cnt", Outstanding_Cnt, 0);
    chk("b_zero_gv", Grant_Valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
